// File: rtl/instr_fetch.sv
// instr_fetch: byte-serial instruction fetcher that assembles opcode, opext and immediate
// under control of an external length decoder and hands the result to execute.
module instr_fetch #(
    parameter logic [23:0] RESET_PC = 24'h000000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [23:0] mem_addr,
    output logic        mem_read,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    input  logic        pc_load,
    input  logic [23:0] pc_load_value,
    output logic [7:0]  dec_opcode,
    output logic [7:0]  dec_opext,
    input  logic        dec_need_opext,
    input  logic        dec_need_imm,
    input  logic        dec_imm_size,
    input  logic        dec_error,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  instr_opcode,
    output logic [7:0]  instr_opext,
    output logic [15:0] instr_imm,
    output logic [23:0] instr_pc,
    output logic [2:0]  instr_len,
    output logic        instr_illegal
);
    typedef enum logic [2:0] {FETCH_OP, FETCH_EXT, FETCH_IMM_LO, FETCH_IMM_HI, HOLD} state_t;

    state_t      state_q, state_d;
    logic        active_q;
    logic [23:0] pc_q, pc_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  opext_q, opext_d;
    logic [15:0] imm_q, imm_d;
    logic [23:0] ipc_q, ipc_d;
    logic [2:0]  len_q, len_d;
    logic        illegal_q, illegal_d;
    logic        size_q, size_d;
    logic        take;

    // active_q keeps the bus quiet until the first edge after reset release
    assign mem_read      = active_q && state_q != HOLD;
    assign mem_addr      = pc_q;
    assign take          = mem_read && mem_ready && !pc_load;
    assign dec_opcode    = (mem_read && state_q == FETCH_OP) ? mem_rdata : opcode_q;
    assign dec_opext     = (mem_read && state_q == FETCH_EXT) ? mem_rdata : opext_q;
    assign instr_valid   = state_q == HOLD && !pc_load;
    assign instr_opcode  = opcode_q;
    assign instr_opext   = opext_q;
    assign instr_imm     = imm_q;
    assign instr_pc      = ipc_q;
    assign instr_len     = len_q;
    assign instr_illegal = illegal_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        opext_d   = opext_q;
        imm_d     = imm_q;
        ipc_d     = ipc_q;
        len_d     = len_q;
        illegal_d = illegal_q;
        size_d    = size_q;
        if (pc_load) begin
            pc_d    = pc_load_value;
            state_d = FETCH_OP;
        end else if (state_q == HOLD) begin
            state_d = instr_ready ? FETCH_OP : HOLD;
        end else if (take) begin
            pc_d  = pc_q + 24'd1;
            len_d = len_q + 3'd1;
            case (state_q)
                FETCH_OP: begin
                    opcode_d  = mem_rdata;
                    ipc_d     = pc_q;
                    opext_d   = 8'h00;
                    imm_d     = 16'h0000;
                    len_d     = 3'd1;
                    size_d    = dec_imm_size;
                    // dec_error refers to a stale opext while an extension byte is pending
                    illegal_d = !dec_need_opext && dec_error;
                    state_d   = dec_need_opext ? FETCH_EXT :
                                dec_error      ? HOLD :
                                dec_need_imm   ? FETCH_IMM_LO : HOLD;
                end
                FETCH_EXT: begin
                    opext_d   = mem_rdata;
                    size_d    = dec_imm_size;
                    illegal_d = dec_error;
                    state_d   = dec_error ? HOLD : dec_need_imm ? FETCH_IMM_LO : HOLD;
                end
                FETCH_IMM_LO: begin
                    imm_d   = {8'h00, mem_rdata};
                    state_d = size_q ? FETCH_IMM_HI : HOLD;
                end
                FETCH_IMM_HI: begin
                    imm_d[15:8] = mem_rdata;
                    state_d     = HOLD;
                end
                default: state_d = FETCH_OP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FETCH_OP;
            active_q  <= 1'b0;
            pc_q      <= RESET_PC;
            opcode_q  <= 8'h00;
            opext_q   <= 8'h00;
            imm_q     <= 16'h0000;
            ipc_q     <= 24'h000000;
            len_q     <= 3'd0;
            illegal_q <= 1'b0;
            size_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= 1'b1;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            opext_q   <= opext_d;
            imm_q     <= imm_d;
            ipc_q     <= ipc_d;
            len_q     <= len_d;
            illegal_q <= illegal_d;
            size_q    <= size_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed tests of instr_fetch against a small memory image and a
// behavioural length decoder.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] mem_addr;
    logic        mem_read;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        pc_load = 1'b0;
    logic [23:0] pc_load_value = 24'h0;
    logic [7:0]  dec_opcode, dec_opext;
    logic        dec_need_opext, dec_need_imm, dec_imm_size, dec_error;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [7:0]  instr_opcode, instr_opext;
    logic [15:0] instr_imm;
    logic [23:0] instr_pc;
    logic [2:0]  instr_len;
    logic        instr_illegal;
    logic [7:0]  mem [0:31];
    int          dly = 0;
    int          cnt = 0;
    int          checks = 0;
    int          errors = 0;

    instr_fetch dut (
        .clk(clk), .reset_n(reset_n),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_load(pc_load), .pc_load_value(pc_load_value),
        .dec_opcode(dec_opcode), .dec_opext(dec_opext),
        .dec_need_opext(dec_need_opext), .dec_need_imm(dec_need_imm),
        .dec_imm_size(dec_imm_size), .dec_error(dec_error),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_opext(instr_opext), .instr_imm(instr_imm),
        .instr_pc(instr_pc), .instr_len(instr_len), .instr_illegal(instr_illegal)
    );

    always #5 clk = ~clk;

    // Memory image: low 32 bytes from mem[], C2 at FFFFFF, zero elsewhere (incl. 001000)
    assign mem_rdata = mem_addr == 24'hFFFFFF ? 8'hC2 :
                       mem_addr < 24'd32 ? mem[mem_addr[4:0]] : 8'h00;
    assign mem_ready = cnt == dly;
    always @(posedge clk) cnt <= (!mem_read || mem_ready) ? 0 : cnt + 1;

    // Decoder: C4 imm16, C2 imm8, FE illegal, CE needs opext (D0 imm16, 00 imm8, else illegal)
    wire ext_ok = dec_opext == 8'hD0 || dec_opext == 8'h00;
    wire is_ce  = dec_opcode == 8'hCE;
    assign dec_need_opext = is_ce;
    assign dec_need_imm   = dec_opcode == 8'hC4 || dec_opcode == 8'hC2 || (is_ce && ext_ok);
    assign dec_imm_size   = dec_opcode == 8'hC4 || (is_ce && dec_opext == 8'hD0);
    assign dec_error      = dec_opcode == 8'hFE || (is_ce && !ext_ok);

    wire [59:0] got = {instr_opcode, instr_opext, instr_imm, instr_pc, instr_len, instr_illegal};

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic handshake();
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_read, instr_valid, got, dec_opcode, dec_opext} !== 78'h0) begin
            errors++;
            $display("FAIL reset outputs: got rd=%b v=%b instr=%h dop=%h dext=%h required all zero",
                     mem_read, instr_valid, got, dec_opcode, dec_opext);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_read, mem_addr} !== {1'b1, 24'h000000}) begin
            errors++;
            $display("FAIL first fetch: got rd=%b addr=%h required rd=1 addr=000000", mem_read, mem_addr);
        end
    endtask

    task automatic test_result(input string name, input logic [59:0] exp, input logic [23:0] next);
        bit ok;
        wait_valid(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s valid timeout: got instr_valid=0 required 1", name);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s result: got %h required %h", name, got, exp);
        end
        handshake();
        checks++;
        if ({mem_read, mem_addr} !== {1'b1, next}) begin
            errors++;
            $display("FAIL %s next fetch: got rd=%b addr=%h required rd=1 addr=%h", name, mem_read, mem_addr, next);
        end
    endtask

    task automatic test_hold_stable();
        bit ok;
        int bad = 0;
        logic [59:0] exp = {8'hCE, 8'h00, 16'h005A, 24'h00000B, 3'd3, 1'b0};
        wait_valid(ok);
        for (int i = 0; i < 5; i++) begin
            if (!instr_valid || mem_read || got !== exp) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold stable: got %0d unstable cycles required 0 (last %h v=%b rd=%b)",
                     bad, got, instr_valid, mem_read);
        end
        test_result("ext_imm8", exp, 24'h00000E);
    endtask

    task automatic test_mem_wait();
        int bad = 0;
        logic [23:0] paddr;
        dly = 3;
        for (int i = 0; i < 60 && !instr_valid; i++) begin
            if (mem_read && !mem_ready) begin
                paddr = mem_addr;
                @(negedge clk);
                if (!mem_read || mem_addr !== paddr) bad++;
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wait stable: got %0d address changes during stall required 0", bad);
        end
        dly = 0;
        test_result("mem_wait", {8'hC4, 8'h00, 16'h1234, 24'h00000E, 3'd3, 1'b0}, 24'h000011);
    endtask

    task automatic test_pc_load();
        @(negedge clk);
        checks++;
        if (mem_addr !== 24'h000012) begin
            errors++;
            $display("FAIL imm_lo addr: got %h required 000012", mem_addr);
        end
        pc_load = 1'b1;
        pc_load_value = 24'h001000;
        @(negedge clk);
        pc_load = 1'b0;
        checks++;
        if ({instr_valid, mem_read, mem_addr} !== {1'b0, 1'b1, 24'h001000}) begin
            errors++;
            $display("FAIL redirect: got v=%b rd=%b addr=%h required v=0 rd=1 addr=001000",
                     instr_valid, mem_read, mem_addr);
        end
        test_result("redirect", {8'h00, 8'h00, 16'h0000, 24'h001000, 3'd1, 1'b0}, 24'h001001);
    endtask

    task automatic test_wrap();
        pc_load = 1'b1;
        pc_load_value = 24'hFFFFFF;
        @(negedge clk);
        pc_load = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_read, mem_addr} !== {1'b1, 24'h000000}) begin
            errors++;
            $display("FAIL wrap addr: got rd=%b addr=%h required rd=1 addr=000000", mem_read, mem_addr);
        end
        test_result("wrap", {8'hC2, 8'h00, 16'h0000, 24'hFFFFFF, 3'd2, 1'b0}, 24'h000001);
    endtask

    task automatic test_reset_mid();
        pc_load = 1'b1;
        pc_load_value = 24'h000007;
        @(negedge clk);
        pc_load = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_addr !== 24'h000008) begin
            errors++;
            $display("FAIL ext addr: got %h required 000008", mem_addr);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({instr_valid, mem_read, instr_opcode, dec_opcode, instr_len} !== 19'h0) begin
            errors++;
            $display("FAIL mid reset: got v=%b rd=%b op=%h dop=%h len=%0d required all zero",
                     instr_valid, mem_read, instr_opcode, dec_opcode, instr_len);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_read, mem_addr} !== {1'b1, 24'h000000}) begin
            errors++;
            $display("FAIL post reset fetch: got rd=%b addr=%h required rd=1 addr=000000", mem_read, mem_addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[1] = 8'hC4;  mem[2] = 8'h34;  mem[3] = 8'h12;
        mem[4] = 8'hFE;
        mem[5] = 8'hCE;  mem[6] = 8'h70;
        mem[7] = 8'hCE;  mem[8] = 8'hD0;  mem[9] = 8'h78;  mem[10] = 8'h56;
        mem[11] = 8'hCE; mem[12] = 8'h00; mem[13] = 8'h5A;
        mem[14] = 8'hC4; mem[15] = 8'h34; mem[16] = 8'h12;
        mem[17] = 8'hC4; mem[18] = 8'h34; mem[19] = 8'h12;
        test_reset();
        test_result("single", {8'h00, 8'h00, 16'h0000, 24'h000000, 3'd1, 1'b0}, 24'h000001);
        test_result("imm16", {8'hC4, 8'h00, 16'h1234, 24'h000001, 3'd3, 1'b0}, 24'h000004);
        test_result("illegal_op", {8'hFE, 8'h00, 16'h0000, 24'h000004, 3'd1, 1'b1}, 24'h000005);
        test_result("illegal_ext", {8'hCE, 8'h70, 16'h0000, 24'h000005, 3'd2, 1'b1}, 24'h000007);
        test_result("ext_imm16", {8'hCE, 8'hD0, 16'h5678, 24'h000007, 3'd4, 1'b0}, 24'h00000B);
        test_hold_stable();
        test_mem_wait();
        test_pc_load();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
